signal_qam_mapper: RTL and testbench
====================================

Name: signal_qam_mapper

Overview:
- Constellation mapper for the signal segment.
- Collects a serial bit stream into groups of 1/2/4 bits (BPSK/QPSK/16-QAM) and emits one signed 12-bit I/Q point per group.
- Output feeds the signal-side constellation scramble stage directly: signal_do_re/im/vld connect to its signal_di_re/im/vld.
- Built-in backpressure guarantees at least one idle cycle between output points, which the scramble stage requires.

Parameters:
- BPSK_AMP, 1024, BPSK amplitude (12-bit signed, positive).
- QPSK_AMP, 724, per-axis QPSK amplitude (≈1024/√2).
- QAM16_UNIT, 324, 16-QAM unit level (≈1024/√10); outer level = 3*QAM16_UNIT = 972.

Ports:
- signal_clk  in  1  working clock
- signal_rst  in  1  asynchronous reset, active high
- mode  in  2  0=BPSK, 1=QPSK, 2=16-QAM, 3=reserved (treated as BPSK)
- bit_di  in  1  serial input bit
- bit_di_vld  in  1  input bit valid
- bit_di_rdy  out  1  mapper can accept a bit this cycle
- flush  in  1  pad partial group with zeros and emit
- signal_do_re  out  12  mapped point, real part, signed
- signal_do_im  out  12  mapped point, imag part, signed
- signal_do_vld  out  1  output point valid, one-cycle pulse
- pt_cnt  out  8  emitted-point counter, wraps 255->0

Behaviour:
- Reset values: signal_do_re=0, signal_do_im=0, signal_do_vld=0, pt_cnt=0, bit_di_rdy=1. Internal state: COLLECT, bit count 0, collector 0.
- Reset is asynchronous; asserting it mid-group discards partial bits, with no output.
- Group size N: 1 (BPSK), 2 (QPSK), 4 (16-QAM).
- Mode is latched when the first bit of a group is accepted. Mode changes mid-group are ignored.
- Bit b0 is the first bit received in a group.
- FSM COLLECT:
  - bit_di_rdy=1.
  - A bit is accepted when bit_di_vld=1; it is stored at position cnt and cnt increments.
  - If the accepted bit completes the group (cnt==N-1):
    - Map on that edge: signal_do_* registered, signal_do_vld<=1, pt_cnt++.
    - cnt<=0; go to HOLD.
- FSM HOLD:
  - bit_di_rdy=0, signal_do_vld=1 for exactly this cycle.
  - Next edge: signal_do_vld<=0, go to COLLECT.
  - signal_do_re/im hold their value until the next point.
- Latency: the output is valid in the cycle after the last bit of the group is accepted.
- Throughput: minimum spacing between signal_do_vld pulses is 2 cycles (BPSK with continuous input).
- bit_di_vld while bit_di_rdy=0 is ignored; the bit is not consumed and the source must hold it.
- Flush, in COLLECT:
  - With cnt>0: missing bits are padded with 0 and the point is emitted as if the group had completed.
  - If flush and bit_di_vld are both high, the bit is accepted first, then padding is applied.
  - If that bit completes the group, emission is normal (no extra point).
  - With cnt==0 and no bit: no effect.
  - In HOLD: ignored.
- Mapping:
  - BPSK: b0=0 -> (+BPSK_AMP, 0); b0=1 -> (-BPSK_AMP, 0).
  - QPSK: re = b0 ? -QPSK_AMP : +QPSK_AMP; im = b1 ? -QPSK_AMP : +QPSK_AMP.
  - 16-QAM, Gray coded; (b0,b1) select re, (b2,b3) select im:
    - 00 -> -3U
    - 01 -> -1U
    - 11 -> +1U
    - 10 -> +3U
    - U = QAM16_UNIT
- Arithmetic: all levels are constants computed at elaboration. There is no runtime multiply and no saturation needed, since |972| < 2047.

Optional Feature:
- SIG_QAM16_EN defined: 16-QAM (mode 2) supported as above.
- Not defined:
  - mode 2 is treated as QPSK (N=2, QPSK mapping).
  - 16-QAM level logic and 4-bit collector positions 2-3 are not synthesized.
  - All other behaviour is identical.

Test Plan:
- Reset, then mode=0 with continuous bit_di_vld=1 and bits 0,1: outputs (1024,0) then (-1024,0); vld pulses exactly 2 cycles apart; bit_di_rdy=0 in each vld cycle; pt_cnt=2.
- mode=1 with bits 1,0: one point (-724,+724), vld in the cycle after the 2nd bit.
- mode=2 (SIG_QAM16_EN) with bits 1,0,0,1: point (+972,-324). Without the macro, the same bits give two QPSK points (-724,+724) and (+724,-724).
- mode=2, feed bits 1,1, then pulse flush: point (+324,-972); pt_cnt increments by 1. Flush with cnt==0 produces no output.
- Assert signal_rst after 3 of 4 16-QAM bits: all outputs return to 0 immediately, no point emitted. After release, a fresh 4-bit group maps correctly.
- 256 BPSK points: pt_cnt wraps to 0. Toggling mode mid-QPSK-group does not alter the group's mapping.

Source files
------------

// File: rtl/signal_qam_mapper.sv
// signal_qam_mapper: serial bits to BPSK/QPSK/16-QAM I/Q points, one idle cycle enforced after each point.
// Optional 16-QAM support is enabled by defining SIG_QAM16_EN; otherwise mode 2 maps as QPSK.
module signal_qam_mapper #(
    parameter int BPSK_AMP   = 1024,
    parameter int QPSK_AMP   = 724,
    parameter int QAM16_UNIT = 324
) (
    input  logic        signal_clk,
    input  logic        signal_rst,
    input  logic [1:0]  mode,
    input  logic        bit_di,
    input  logic        bit_di_vld,
    output logic        bit_di_rdy,
    input  logic        flush,
    output logic [11:0] signal_do_re,
    output logic [11:0] signal_do_im,
    output logic        signal_do_vld,
    output logic [7:0]  pt_cnt
);
    typedef enum logic {COLLECT, HOLD} state_t;
    typedef enum logic [1:0] {M_BPSK, M_QPSK, M_QAM16} gmode_t;

    localparam logic [11:0] B_P = 12'(BPSK_AMP);
    localparam logic [11:0] B_N = 12'(-BPSK_AMP);
    localparam logic [11:0] Q_P = 12'(QPSK_AMP);
    localparam logic [11:0] Q_N = 12'(-QPSK_AMP);
`ifdef SIG_QAM16_EN
    localparam int CW = 4;
    localparam logic [11:0] U1_P = 12'(QAM16_UNIT);
    localparam logic [11:0] U1_N = 12'(-QAM16_UNIT);
    localparam logic [11:0] U3_P = 12'(3 * QAM16_UNIT);
    localparam logic [11:0] U3_N = 12'(-3 * QAM16_UNIT);

    // Gray-coded level: first bit picks the sign, second bit picks inner vs outer.
    function automatic logic [11:0] lvl(input logic f, input logic s);
        return f ? (s ? U1_P : U3_P) : (s ? U1_N : U3_N);
    endfunction
`else
    localparam int CW = 2;
`endif

    function automatic gmode_t eff_mode(input logic [1:0] m);
`ifdef SIG_QAM16_EN
        return m == 2'd1 ? M_QPSK : m == 2'd2 ? M_QAM16 : M_BPSK;
`else
        return (m == 2'd1 || m == 2'd2) ? M_QPSK : M_BPSK;
`endif
    endfunction

    state_t         state_q, state_d;
    gmode_t         gm_q, gm_d, gm;
    logic [1:0]     cnt_q, cnt_d, last_idx;
    logic [CW-1:0]  col_q, col_d, bits;
    logic [11:0]    re_q, re_d, im_q, im_d, map_re, map_im;
    logic           vld_q, vld_d, acc, emit;
    logic [7:0]     pt_cnt_q, pt_cnt_d;

    always_ff @(posedge signal_clk or posedge signal_rst) begin
        if (signal_rst) begin
            state_q  <= COLLECT;
            gm_q     <= M_BPSK;
            cnt_q    <= '0;
            col_q    <= '0;
            re_q     <= '0;
            im_q     <= '0;
            vld_q    <= 1'b0;
            pt_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            gm_q     <= gm_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            re_q     <= re_d;
            im_q     <= im_d;
            vld_q    <= vld_d;
            pt_cnt_q <= pt_cnt_d;
        end
    end

    always_comb begin
        bit_di_rdy = state_q == COLLECT;
        acc        = bit_di_rdy && bit_di_vld;
        // Group mode is taken live only for the first bit; later bits use the latched copy.
        gm         = cnt_q == 2'd0 ? eff_mode(mode) : gm_q;
        last_idx   = gm == M_QAM16 ? 2'd3 : gm == M_QPSK ? 2'd1 : 2'd0;
        bits       = col_q;
        for (int i = 0; i < CW; i++)
            if (acc && cnt_q == 2'(i)) bits[i] = bit_di;
        // Unfilled positions are already zero, so flush padding is implicit.
        emit       = bit_di_rdy && ((acc && cnt_q == last_idx) || (flush && (acc || cnt_q != 2'd0)));
        map_re     = gm == M_BPSK ? (bits[0] ? B_N : B_P) : (bits[0] ? Q_N : Q_P);
        map_im     = gm == M_BPSK ? 12'd0 : (bits[1] ? Q_N : Q_P);
`ifdef SIG_QAM16_EN
        map_re     = gm == M_QAM16 ? lvl(bits[0], bits[1]) : map_re;
        map_im     = gm == M_QAM16 ? lvl(bits[2], bits[3]) : map_im;
`endif
        state_d    = emit ? HOLD : COLLECT;
        gm_d       = (acc && cnt_q == 2'd0) ? gm : gm_q;
        cnt_d      = emit ? 2'd0 : acc ? cnt_q + 2'd1 : cnt_q;
        col_d      = emit ? '0 : bits;
        re_d       = emit ? map_re : re_q;
        im_d       = emit ? map_im : im_q;
        vld_d      = emit;
        pt_cnt_d   = emit ? pt_cnt_q + 8'd1 : pt_cnt_q;
    end

    assign signal_do_re  = re_q;
    assign signal_do_im  = im_q;
    assign signal_do_vld = vld_q;
    assign pt_cnt        = pt_cnt_q;
endmodule

// File: tb/tb_signal_qam_mapper.sv
// tb_signal_qam_mapper: directed vector table plus hand sequences for timing, flush, reset and wrap.
module tb_signal_qam_mapper;
    logic        signal_clk = 1'b0;
    logic        signal_rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        bit_di = 1'b0;
    logic        bit_di_vld = 1'b0;
    logic        bit_di_rdy;
    logic        flush = 1'b0;
    logic [11:0] signal_do_re, signal_do_im;
    logic        signal_do_vld;
    logic [7:0]  pt_cnt;
    int          n_chk = 0;
    int          n_pass = 0;
    int          exp_cnt = 0;

    typedef struct {
        logic [1:0] m;
        int         n;
        logic [3:0] b;
        logic       fl;
        int         re;
        int         im;
    } vec_t;
    vec_t vecs[$];

    signal_qam_mapper dut (
        .signal_clk(signal_clk), .signal_rst(signal_rst), .mode(mode),
        .bit_di(bit_di), .bit_di_vld(bit_di_vld), .bit_di_rdy(bit_di_rdy),
        .flush(flush), .signal_do_re(signal_do_re), .signal_do_im(signal_do_im),
        .signal_do_vld(signal_do_vld), .pt_cnt(pt_cnt)
    );

    always #5 signal_clk = ~signal_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge signal_clk);
        #1;
    endtask

    task automatic wait_rdy();
        int k = 0;
        while (!bit_di_rdy && k < 10) begin
            tick();
            k++;
        end
        if (!bit_di_rdy) chk("rdy_timeout", 0, 1);
    endtask

    task automatic chk_pt(input string nm, input int re, input int im);
        exp_cnt = (exp_cnt + 1) % 256;
        chk({nm, "_vld"}, int'(signal_do_vld), 1);
        chk({nm, "_re"}, int'($signed(signal_do_re)), re);
        chk({nm, "_im"}, int'($signed(signal_do_im)), im);
        chk({nm, "_cnt"}, int'(pt_cnt), exp_cnt);
        chk({nm, "_rdy"}, int'(bit_di_rdy), 0);
        tick();
        chk({nm, "_vld_off"}, int'(signal_do_vld), 0);
    endtask

    task automatic send(input string nm, input vec_t v);
        mode = v.m;
        for (int i = 0; i < v.n; i++) begin
            bit_di = v.b[i];
            bit_di_vld = 1'b1;
            wait_rdy();
            tick();
        end
        bit_di_vld = 1'b0;
        if (v.fl) begin
            chk({nm, "_no_early"}, int'(signal_do_vld), 0);
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        chk_pt(nm, v.re, v.im);
    endtask

    initial begin
        vecs.push_back('{2'd0, 1, 4'b0000, 1'b0, 1024, 0});
        vecs.push_back('{2'd0, 1, 4'b0001, 1'b0, -1024, 0});
        vecs.push_back('{2'd1, 2, 4'b0001, 1'b0, -724, 724});
        vecs.push_back('{2'd1, 2, 4'b0010, 1'b0, 724, -724});
        vecs.push_back('{2'd1, 2, 4'b0011, 1'b0, -724, -724});
        vecs.push_back('{2'd1, 2, 4'b0000, 1'b0, 724, 724});
        vecs.push_back('{2'd3, 1, 4'b0001, 1'b0, -1024, 0});
        vecs.push_back('{2'd1, 1, 4'b0001, 1'b1, -724, 724});
`ifdef SIG_QAM16_EN
        vecs.push_back('{2'd2, 4, 4'b1001, 1'b0, 972, -324});
        vecs.push_back('{2'd2, 4, 4'b1100, 1'b0, -972, 324});
        vecs.push_back('{2'd2, 4, 4'b0110, 1'b0, -324, 972});
        vecs.push_back('{2'd2, 4, 4'b1111, 1'b0, 324, 324});
        vecs.push_back('{2'd2, 2, 4'b0011, 1'b1, 324, -972});
        vecs.push_back('{2'd2, 3, 4'b0111, 1'b1, 324, 972});
`else
        vecs.push_back('{2'd2, 2, 4'b0001, 1'b0, -724, 724});
        vecs.push_back('{2'd2, 2, 4'b0010, 1'b0, 724, -724});
        vecs.push_back('{2'd2, 1, 4'b0001, 1'b1, -724, 724});
`endif

        tick();
        chk("rst_re", int'(signal_do_re), 0);
        chk("rst_im", int'(signal_do_im), 0);
        chk("rst_vld", int'(signal_do_vld), 0);
        chk("rst_cnt", int'(pt_cnt), 0);
        chk("rst_rdy", int'(bit_di_rdy), 1);
        signal_rst = 1'b0;
        tick();

        // BPSK continuous input: pulses two cycles apart
        mode = 2'd0; bit_di = 1'b0; bit_di_vld = 1'b1;
        tick();
        chk("bpsk0_vld", int'(signal_do_vld), 1);
        chk("bpsk0_re", int'($signed(signal_do_re)), 1024);
        chk("bpsk0_im", int'($signed(signal_do_im)), 0);
        chk("bpsk0_rdy", int'(bit_di_rdy), 0);
        bit_di = 1'b1;
        tick();
        chk("bpsk_gap_vld", int'(signal_do_vld), 0);
        chk("bpsk_gap_rdy", int'(bit_di_rdy), 1);
        tick();
        bit_di_vld = 1'b0;
        chk("bpsk1_vld", int'(signal_do_vld), 1);
        chk("bpsk1_re", int'($signed(signal_do_re)), -1024);
        chk("bpsk1_rdy", int'(bit_di_rdy), 0);
        chk("bpsk1_cnt", int'(pt_cnt), 2);
        exp_cnt = 2;
        tick();

        foreach (vecs[i]) send($sformatf("vec%0d", i), vecs[i]);

        // Flush with nothing collected does nothing
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle_vld", int'(signal_do_vld), 0);
        tick();
        chk("flush_idle_vld2", int'(signal_do_vld), 0);
        chk("flush_idle_cnt", int'(pt_cnt), exp_cnt);

        // Flush together with a first QPSK bit pads and emits
        mode = 2'd1; bit_di = 1'b1; bit_di_vld = 1'b1; flush = 1'b1;
        tick();
        bit_di_vld = 1'b0; flush = 1'b0;
        chk_pt("flush_bit", -724, 724);

        // Flush together with the completing bit gives one normal point only
        bit_di = 1'b0; bit_di_vld = 1'b1;
        tick();
        bit_di = 1'b1; flush = 1'b1;
        tick();
        bit_di_vld = 1'b0; flush = 1'b0;
        chk_pt("flush_last", 724, -724);
        chk("flush_last_cnt", int'(pt_cnt), exp_cnt);

        // Mode change mid-group is ignored
        mode = 2'd1; bit_di = 1'b1; bit_di_vld = 1'b1;
        tick();
        mode = 2'd0; bit_di = 1'b0;
        tick();
        bit_di_vld = 1'b0;
        chk_pt("mode_toggle", -724, 724);

        // Asynchronous reset mid-group
`ifdef SIG_QAM16_EN
        mode = 2'd2;
        for (int i = 0; i < 3; i++) begin
`else
        mode = 2'd1;
        for (int i = 0; i < 1; i++) begin
`endif
            bit_di = 1'b1; bit_di_vld = 1'b1;
            tick();
        end
        bit_di_vld = 1'b0;
        chk("partial_no_vld", int'(signal_do_vld), 0);
        #2 signal_rst = 1'b1;
        #1;
        chk("arst_re", int'(signal_do_re), 0);
        chk("arst_im", int'(signal_do_im), 0);
        chk("arst_vld", int'(signal_do_vld), 0);
        chk("arst_cnt", int'(pt_cnt), 0);
        chk("arst_rdy", int'(bit_di_rdy), 1);
        tick();
        signal_rst = 1'b0;
        exp_cnt = 0;
        tick();
`ifdef SIG_QAM16_EN
        send("post_rst", '{2'd2, 4, 4'b1001, 1'b0, 972, -324});
`else
        send("post_rst", '{2'd1, 2, 4'b0001, 1'b0, -724, 724});
`endif

        // 255 more points wrap the counter to 0
        for (int i = 0; i < 255; i++) send("wrap", '{2'd0, 1, 4'(i & 1), 1'b0, (i & 1) ? -1024 : 1024, 0});
        chk("wrap_cnt", int'(pt_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
